// File: rtl/output_scheduler.sv
// Round-robin capture of one of four 32-bit values, shown as sign + 3 BCD digits; grant to Done is 11 cycles.
// No backpressure: requesters hold Req until their Grant, requests outside IDLE are ignored (not queued).
module output_scheduler #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic [3:0]   Req,
  input  logic [127:0] Dado,
  output logic [3:0]   Grant,
  output logic         Busy,
  output logic         Done,
  output logic [6:0]   Display1,
  output logic [6:0]   Display2,
  output logic [6:0]   Display3,
  output logic [6:0]   Display4,
  output logic [10:0]  LEDs,
  output logic         Ovf
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] SHOW    = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  logic [1:0]  state;
  logic [1:0]  last;
  logic [10:0] raw_q;
  logic        sign_q;
  logic        ovf_q;
  logic [9:0]  bin_q;
  logic [11:0] bcd_q;
  logic [3:0]  iter_q;
  logic [7:0]  hold_q;

  logic [1:0]  pick_idx;
  logic        pick_vld;
  logic        sel_sign;
  logic [10:0] sel_raw;
  logic [9:0]  sel_low;
  logic        sel_ovf;
  logic [9:0]  sel_opd;
  logic [3:0]  units_adj;
  logic [3:0]  tens_adj;
  logic [11:0] bcd_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last;
    for (int i = 1; i <= 4; i++) begin
      if (!pick_vld && Req[last + 2'(i)]) begin
        pick_vld = 1'b1;
        pick_idx = last + 2'(i);
      end
    end
  end

  // Low bits of a two's-complement negation depend only on the low bits of the input.
  assign sel_sign = Dado[{pick_idx, 5'd31}];
  assign sel_raw  = Dado[{pick_idx, 5'd0} +: 11];
  assign sel_low  = sel_sign ? (~sel_raw[9:0] + 10'd1) : sel_raw[9:0];
  assign sel_ovf  = (sel_low > 10'd999);
  assign sel_opd  = sel_ovf ? 10'd999 : sel_low;

  // Operand never exceeds 999, so the hundreds digit is below 5 before every shift.
  assign units_adj = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
  assign tens_adj  = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
  assign bcd_nxt   = {bcd_q[10:8], tens_adj, units_adj, bin_q[9]};

  assign Busy = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state    <= IDLE;
      last     <= 2'd3;
      raw_q    <= '0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      bin_q    <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      hold_q   <= '0;
      Grant    <= '0;
      Done     <= 1'b0;
      Display1 <= 7'b1111111;
      Display2 <= 7'b1111111;
      Display3 <= 7'b1111111;
      Display4 <= 7'b1111111;
      LEDs     <= '0;
      Ovf      <= 1'b0;
    end else begin
      Grant <= '0;
      Done  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            raw_q  <= sel_raw;
            sign_q <= sel_sign;
            ovf_q  <= sel_ovf;
            bin_q  <= sel_opd;
            bcd_q  <= '0;
            iter_q <= '0;
            Grant  <= 4'b0001 << pick_idx;
            last   <= pick_idx;
            state  <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_q  <= bcd_nxt;
          bin_q  <= {bin_q[8:0], 1'b0};
          iter_q <= iter_q + 4'd1;
          if (iter_q == 4'd9) state <= SHOW;
        end
        SHOW: begin
          Display1 <= seg7(bcd_q[3:0]);
          Display2 <= seg7(bcd_q[7:4]);
          Display3 <= seg7(bcd_q[11:8]);
          Display4 <= sign_q ? 7'b1111110 : 7'b1111111;
          LEDs     <= raw_q;
          Ovf      <= ovf_q;
          Done     <= 1'b1;
          hold_q   <= 8'(HOLD_CYCLES);
          state    <= HOLD;
        end
        HOLD: begin
          if (hold_q <= 8'd1) begin
            hold_q <= '0;
            state  <= IDLE;
          end else begin
            hold_q <= hold_q - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_scheduler.sv
// Randomized bench for output_scheduler: a cycle-level reference model queues expected grants/results,
// a monitor on the falling edge pops and compares them against the DUT.
module tb_output_scheduler;
  localparam int H = 4;

  logic         CLK = 1'b0;
  logic         Reset = 1'b0;
  logic [3:0]   Req = '0;
  logic [127:0] Dado = '0;
  logic [3:0]   Grant;
  logic         Busy;
  logic         Done;
  logic [6:0]   Display1, Display2, Display3, Display4;
  logic [10:0]  LEDs;
  logic         Ovf;

  always #5 CLK = ~CLK;

  output_scheduler #(.HOLD_CYCLES(H)) dut (
    .CLK(CLK), .Reset(Reset), .Req(Req), .Dado(Dado),
    .Grant(Grant), .Busy(Busy), .Done(Done),
    .Display1(Display1), .Display2(Display2), .Display3(Display3), .Display4(Display4),
    .LEDs(LEDs), .Ovf(Ovf)
  );

  typedef struct {
    int         edge_no;
    logic [3:0] vec;
  } gexp_t;

  typedef struct {
    int          edge_no;
    logic [6:0]  d1, d2, d3, d4;
    logic [10:0] leds;
    logic        ovf;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = -1;
  int    busy_end = 0;
  int    last_rr = 3;
  logic  busy_exp = 1'b0;
  rexp_t shown;
  rexp_t pend;
  bit    pend_v = 1'b0;
  bit    mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic rexp_t reset_exp();
    rexp_t r;
    r.edge_no = 0;
    r.d1 = 7'b1111111; r.d2 = 7'b1111111; r.d3 = 7'b1111111; r.d4 = 7'b1111111;
    r.leds = '0;
    r.ovf = 1'b0;
    return r;
  endfunction

  function automatic rexp_t expect_of(input logic [31:0] v, input int k);
    rexp_t r;
    logic [31:0] mag;
    int low, n;
    mag = v[31] ? (32'd0 - v) : v;
    low = int'(mag[9:0]);
    n = (low > 999) ? 999 : low;
    r.edge_no = k + 11;
    r.d1 = seg_of(n % 10);
    r.d2 = seg_of((n / 10) % 10);
    r.d3 = seg_of(n / 100);
    r.d4 = v[31] ? 7'b1111110 : 7'b1111111;
    r.leds = v[10:0];
    r.ovf = (low > 999);
    return r;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 6))
      0: return 32'($urandom_range(0, 999));
      1: return 32'd0 - 32'($urandom_range(0, 999));
      2: return 32'h0000_03FF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(1000, 1023));
      5: return 32'd0 - 32'($urandom_range(1000, 1023));
      default: return $urandom;
    endcase
  endfunction

  // Reference model: one grant per idle window, result shown 11 edges later, idle again after HOLD.
  always @(posedge CLK) begin
    cyc++;
    if (!Reset) begin
      busy_end = cyc;
      last_rr = 3;
      gq.delete();
      rq.delete();
      pend_v = 1'b0;
      shown = reset_exp();
    end else begin
      if (pend_v && cyc == pend.edge_no) begin
        shown = pend;
        pend_v = 1'b0;
      end
      if (cyc > busy_end && Req != 4'd0) begin
        int w;
        gexp_t g;
        w = -1;
        for (int s = 1; s <= 4; s++)
          if (w < 0 && Req[(last_rr + s) % 4]) w = (last_rr + s) % 4;
        last_rr = w;
        g.edge_no = cyc;
        g.vec = 4'(1 << w);
        gq.push_back(g);
        pend = expect_of(Dado[32*w +: 32], cyc);
        pend_v = 1'b1;
        rq.push_back(pend);
        busy_end = cyc + 11 + H;
      end
    end
    busy_exp = (cyc < busy_end);
  end

  always @(negedge CLK) begin
    if (mon_en) begin
      if (gq.size() > 0 && gq[0].edge_no < cyc) begin
        fail("grant_missing", -1, gq[0].edge_no);
        void'(gq.pop_front());
      end
      if (Grant != 4'd0) begin
        if (gq.size() == 0) fail("grant_unexpected", int'(Grant), 0);
        else begin
          gexp_t g;
          g = gq.pop_front();
          chk("grant_vec", 32'(Grant), 32'(g.vec));
          chk("grant_cycle", cyc, g.edge_no);
        end
      end
      if (rq.size() > 0 && rq[0].edge_no < cyc) begin
        fail("done_missing", -1, rq[0].edge_no);
        void'(rq.pop_front());
      end
      if (Done) begin
        if (rq.size() == 0) fail("done_unexpected", 1, 0);
        else begin
          rexp_t r;
          r = rq.pop_front();
          chk("done_cycle", cyc, r.edge_no);
        end
      end
      chk("busy", 32'(Busy), 32'(busy_exp));
      chk("display1", 32'(Display1), 32'(shown.d1));
      chk("display2", 32'(Display2), 32'(shown.d2));
      chk("display3", 32'(Display3), 32'(shown.d3));
      chk("display4", 32'(Display4), 32'(shown.d4));
      chk("leds", 32'(LEDs), 32'(shown.leds));
      chk("ovf", 32'(Ovf), 32'(shown.ovf));
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_display1"}, 32'(Display1), 32'h7F);
    chk({tag, "_display2"}, 32'(Display2), 32'h7F);
    chk({tag, "_display3"}, 32'(Display3), 32'h7F);
    chk({tag, "_display4"}, 32'(Display4), 32'h7F);
    chk({tag, "_leds"}, 32'(LEDs), 32'h0);
    chk({tag, "_grant"}, 32'(Grant), 32'h0);
    chk({tag, "_done"}, 32'(Done), 32'h0);
    chk({tag, "_busy"}, 32'(Busy), 32'h0);
    chk({tag, "_ovf"}, 32'(Ovf), 32'h0);
  endtask

  task automatic wait_grant(input int n);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge CLK);
      if (Grant[n]) seen = 1'b1;
    end
    if (!seen) fail("grant_timeout", 0, n);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 200 && !idle; t++) begin
      @(negedge CLK);
      if (!Busy) idle = 1'b1;
    end
    if (!idle) fail("idle_timeout", 1, 0);
    @(negedge CLK);
  endtask

  // Captured value must survive a later change of Dado and the drop of Req.
  task automatic request(input int n, input logic [31:0] v);
    Dado[32*n +: 32] = v;
    Req[n] = 1'b1;
    wait_grant(n);
    Req[n] = 1'b0;
    Dado[32*n +: 32] = ~v;
  endtask

  initial begin
    int grants;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    Reset = 1'b1;
    mon_en = 1'b1;

    request(0, 32'h0000_007B); wait_idle();
    request(1, 32'hFFFF_FFF9); wait_idle();
    request(2, 32'h0000_03FF); wait_idle();
    request(3, 32'h8000_0000); wait_idle();

    Req = 4'hF;
    grants = 0;
    for (int t = 0; t < 200 && grants < 5; t++) begin
      @(negedge CLK);
      for (int n = 0; n < 4; n++) Dado[32*n +: 32] = rand_val();
      if (Grant != 4'd0) grants++;
    end
    if (grants < 5) fail("rr_grant_count", grants, 5);
    Req = 4'h0;
    wait_idle();

    request(1, 32'd456);
    repeat (4) @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    check_reset_outputs("midreset");
    Reset = 1'b1;
    Req = 4'hF;
    @(negedge CLK);
    chk("post_reset_grant", 32'(Grant), 32'h1);
    Req = 4'h0;
    wait_idle();

    for (int t = 0; t < 3000; t++) begin
      @(negedge CLK);
      for (int n = 0; n < 4; n++) begin
        if (Grant[n] && $urandom_range(0, 3) != 0) Req[n] = 1'b0;
        else if (!Req[n] && $urandom_range(0, 7) == 0) Req[n] = 1'b1;
        Dado[32*n +: 32] = rand_val();
      end
      if (!Reset) Reset = 1'b1;
      else if ($urandom_range(0, 399) == 0) Reset = 1'b0;
    end
    Reset = 1'b1;
    Req = 4'h0;
    wait_idle();
    repeat (3) @(negedge CLK);
    chk("grant_queue_empty", gq.size(), 0);
    chk("result_queue_empty", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_scheduler.md
OUTPUT_SCHEDULER -- requirements
Module: output_scheduler

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4: the number of cycles a shown result stays locked before the next grant (legal range 1..255).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port Req, input, 4 bits: write request, one bit per requester 0..3, level-sensitive.
REQ-005 The block SHALL have port Dado, input, 128 bits: requester n's 32-bit two's-complement value on bits [32n+31:32n].
REQ-006 The block SHALL have port Grant, output, 4 bits: one-hot pulse, one cycle long, naming the requester whose value was captured.
REQ-007 The block SHALL have port Busy, output, 1 bit: high whenever the state is not IDLE.
REQ-008 The block SHALL have port Done, output, 1 bit: one-cycle pulse when the displays update.
REQ-009 The block SHALL have ports Display1, Display2, Display3 and Display4, each output, 7 bits, active-low segments: units, tens, hundreds and sign.
REQ-010 The block SHALL have port LEDs, output, 11 bits: bits [10:0] of the captured raw value.
REQ-011 The block SHALL have port Ovf, output, 1 bit: high when the captured magnitude's low 10 bits exceed 999.

Function
REQ-012 The block SHALL implement the states IDLE, CONVERT, SHOW and HOLD.
REQ-013 In IDLE with Req!=0 at edge k, the block SHALL:
- select a requester by round-robin, searching from (last+1) mod 4;
- capture that requester's Dado slice;
- pulse that Grant bit during cycle k..k+1;
- set last to the selected requester;
- enter CONVERT.
REQ-014 In IDLE with Req==0, the block SHALL hold its state and all outputs.
REQ-015 At capture, the sign SHALL be bit 31 of the captured value, and the magnitude SHALL be its two's-complement negation when the sign is 1, otherwise the value unchanged.
REQ-016 The magnitude 0x80000000 SHALL pass through unchanged, giving low 10 bits 0.
REQ-017 The conversion operand SHALL be mag[9:0] saturated to 999; Ovf SHALL be registered high when mag[9:0]>999.
REQ-018 CONVERT SHALL perform one shift-add-3 double-dabble iteration per cycle, MSB first, for exactly 10 cycles (edges k+1..k+10), on a 12-bit hundreds/tens/units register.
REQ-019 After the 10th iteration the block SHALL enter SHOW.
REQ-020 At edge k+11 (SHOW), the block SHALL:
- register the digit segments;
- drive Display4 = 1111110 if the sign is 1, else 1111111;
- drive LEDs = captured[10:0];
- pulse Done for one cycle;
- load the hold counter with HOLD_CYCLES and enter HOLD.
REQ-021 Digit encoding SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, any other value=1111111.
REQ-022 HOLD SHALL last exactly HOLD_CYCLES cycles and return to IDLE at edge k+11+HOLD_CYCLES.
REQ-023 The earliest next grant SHALL be at edge k+12+HOLD_CYCLES.
REQ-024 Req changes outside IDLE SHALL be ignored; no request SHALL be queued, and a requester must hold Req until it sees its Grant.
REQ-025 Display, LEDs and Ovf SHALL hold their values until the next SHOW edge or reset.
REQ-026 The Dado input SHALL be sampled only at the grant edge; later changes SHALL NOT affect the result.

Reset
REQ-027 When Reset==0 at an edge, the block SHALL:
- enter IDLE;
- set Display1..4 = 1111111, LEDs = 0, Grant = 0, Done = 0, Busy = 0, Ovf = 0;
- set last = 3, so requester 0 has first priority;
- clear the conversion register and the counters.
REQ-028 Reset SHALL take priority over every other event.
REQ-029 A reset in CONVERT, SHOW or HOLD SHALL abort the operation with no Done pulse.
REQ-030 No output SHALL change on a Reset edge other than to its reset value.

Verification
REQ-031 Single request, positive value: Req=0001, Dado0=0x0000007B, HOLD_CYCLES=4 -> Grant=0001 one cycle, Busy high, Done at edge k+11; Display3/2/1 = 1001111/0010010/0000110 ("123"), Display4=1111111, LEDs=0x07B, back in IDLE at edge k+15.
REQ-032 Negative value: Dado=0xFFFFFFF9 (-7) -> Display4=1111110, Display3/2/1 = 0000001/0000001/0001111 ("-007"), LEDs=0x7F9, Ovf=0.
REQ-033 Round-robin fairness: Req=1111 held continuously -> grants in the order 0001, 0010, 0100, 1000, 0001, with consecutive grants exactly 12+HOLD_CYCLES cycles apart.
REQ-034 Saturation and edge value: Dado=0x000003FF -> displays "999", Ovf=1; Dado=0x80000000 -> "-000", Ovf=0.
REQ-035 Reset mid-operation: Reset=0 at edge k+5 of a conversion -> next cycle all displays 1111111, LEDs=0, Busy=0, no Done pulse; the next grant with Req=1111 goes to requester 0.
REQ-036 Late input change: Dado changed after the Grant edge and Req dropped during CONVERT -> the result still reflects the captured value, and no extra grant is issued in HOLD.
